// File: rtl/jogo_pkg.sv
// ----------------------------------------------------------------------------
// jogo_pkg
// Shared definitions for the parametrised sequence-memory game:
//   - estado_t : 4-bit state encoding; the codes are visible on db_estado
//   - LFSR_TAPS: Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1
//   - lfsr_passo(): one right-shift Galois step of the 16-bit LFSR
// ----------------------------------------------------------------------------
package jogo_pkg;

    typedef enum logic [3:0] {
        ST_INICIAL        = 4'd0,
        ST_PREENCHE       = 4'd1,
        ST_PREPARA_RODADA = 4'd2,
        ST_MOSTRA_ACESO   = 4'd3,
        ST_MOSTRA_APAGADO = 4'd4,
        ST_ESPERA_JOGADA  = 4'd5,
        ST_COMPARA        = 4'd6,
        ST_PROXIMA_RODADA = 4'd7,
        ST_FINAL_GANHOU   = 4'd8,
        ST_FINAL_PERDEU   = 4'd9
    } estado_t;

    // Right-shift Galois form: bit 0 is the output, the mask is XORed in
    // whenever a 1 is shifted out.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_passo(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/jogo_memoria_param_lfsr16.sv
// ----------------------------------------------------------------------------
// lfsr16
// 16-bit Galois LFSR used to fill the sequence memory.
// Ports:
//   clock    in   system clock
//   reset    in   synchronous active-high reset, reloads the seed
//   carregar in   load semente (has priority over avancar)
//   avancar  in   advance one step
//   semente  in   16-bit seed, must be nonzero
//   valor    out  current LFSR state
// ----------------------------------------------------------------------------
module lfsr16 (
    input  logic        clock,
    input  logic        reset,
    input  logic        carregar,
    input  logic        avancar,
    input  logic [15:0] semente,
    output logic [15:0] valor
);
    import jogo_pkg::*;

    logic [15:0] valor_d;
    logic [15:0] valor_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        valor_d = valor_q;
        if (carregar) begin
            valor_d = semente;
        end else if (avancar) begin
            valor_d = lfsr_passo(valor_q);
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            valor_q <= semente;
        end else begin
            valor_q <= valor_d;
        end
    end

    assign valor = valor_q;

endmodule

// File: rtl/jogo_memoria_param.sv
// ----------------------------------------------------------------------------
// jogo_memoria_param
// Sequence-memory game: fills a memory with LFSR-derived button indices,
// shows a growing prefix on the LEDs each round and checks the player's
// presses against it.
// Ports:
//   clock, reset   system clock, synchronous active-high reset
//   iniciar        start/restart (accepted in inicial and the final states)
//   modo           latched on start: 0 show whole prefix, 1 newest item only
//   chaves         button levels, active-high
//   leds           one-hot LED drive during the show phase, 0 otherwise
//   pronto         high in either final state
//   ganhou/perdeu  high in final_ganhou / final_perdeu
//   db_timeout     loss was caused by the press timeout
//   db_estado      state code
//   db_rodada      current round (0-based), db_endereco current address
//   db_jogada      last registered press
// ----------------------------------------------------------------------------
module jogo_memoria_param #(
    parameter int          N_BOTOES     = 4,
    parameter int          PROFUNDIDADE = 16,
    parameter int          T_MOSTRA     = 1000,
    parameter int          T_TIMEOUT    = 5000,
    parameter logic [15:0] SEMENTE      = 16'hACE1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                iniciar,
    input  logic                modo,
    input  logic [N_BOTOES-1:0] chaves,
    output logic [N_BOTOES-1:0] leds,
    output logic                pronto,
    output logic                ganhou,
    output logic                perdeu,
    output logic                db_timeout,
    output logic [3:0]          db_estado,
    output logic [7:0]          db_rodada,
    output logic [7:0]          db_endereco,
    output logic [N_BOTOES-1:0] db_jogada
);
    import jogo_pkg::*;

    localparam int AW   = ($clog2(PROFUNDIDADE) > 1) ? $clog2(PROFUNDIDADE) : 1;
    localparam int BW   = $clog2(N_BOTOES);
    localparam int TMAX = (T_MOSTRA > T_TIMEOUT) ? T_MOSTRA : T_TIMEOUT;
    // One spare count so the timer may step past T_TIMEOUT-1 when a press
    // wins the expiry cycle.
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] FIM_MOSTRA  = TW'(T_MOSTRA - 1);
    localparam logic [TW-1:0] FIM_TIMEOUT = TW'(T_TIMEOUT - 1);
    localparam logic [AW-1:0] ULTIMO      = AW'(PROFUNDIDADE - 1);

    estado_t             estado_d, estado_q;
    logic                modo_d, modo_q;
    logic [AW-1:0]       end_d, end_q;
    logic [AW-1:0]       rodada_d, rodada_q;
    logic [TW-1:0]       timer_d, timer_q;
    logic                timeout_d, timeout_q;
    logic [N_BOTOES-1:0] jogada_d, jogada_q;
    logic                chaves_ant_d, chaves_ant_q;
    logic [N_BOTOES-1:0] leds_d, leds_q;
    logic                pronto_d, pronto_q;
    logic                ganhou_d, ganhou_q;
    logic                perdeu_d, perdeu_q;

    logic [BW-1:0]       mem_q [PROFUNDIDADE];
    logic                mem_we;
    logic [BW-1:0]       mem_wdata;

    logic                lfsr_carregar;
    logic                lfsr_avancar;
    logic [15:0]         lfsr_valor;

    logic [N_BOTOES-1:0] alvo;
    logic                jogada_unica;
    logic                pressionou;

    lfsr16 u_lfsr (
        .clock    (clock),
        .reset    (reset),
        .carregar (lfsr_carregar),
        .avancar  (lfsr_avancar),
        .semente  (SEMENTE),
        .valor    (lfsr_valor)
    );

    assign alvo         = N_BOTOES'(1) << mem_q[end_q];
    assign jogada_unica = (jogada_q != '0) && ((jogada_q & (jogada_q - N_BOTOES'(1))) == '0);
    // Rising edge of "any button": a button held through the show phase
    // keeps chaves_ant_q high and so cannot count as a press.
    assign pressionou   = (|chaves) && !chaves_ant_q;

    always_comb begin
        estado_d      = estado_q;
        modo_d        = modo_q;
        end_d         = end_q;
        rodada_d      = rodada_q;
        timer_d       = timer_q;
        timeout_d     = timeout_q;
        jogada_d      = jogada_q;
        chaves_ant_d  = |chaves;
        mem_we        = 1'b0;
        mem_wdata     = BW'(lfsr_valor % 16'(N_BOTOES));
        lfsr_carregar = 1'b0;
        lfsr_avancar  = 1'b0;

        case (estado_q)
            ST_INICIAL, ST_FINAL_GANHOU, ST_FINAL_PERDEU: ;
            ST_PREENCHE: begin
                mem_we       = 1'b1;
                lfsr_avancar = 1'b1;
                if (end_q == ULTIMO) estado_d = ST_PREPARA_RODADA;
                else                 end_d    = end_q + AW'(1);
            end
            ST_PREPARA_RODADA: begin
                end_d    = modo_q ? rodada_q : '0;
                timer_d  = '0;
                estado_d = ST_MOSTRA_ACESO;
            end
            ST_MOSTRA_ACESO: begin
                if (timer_q == FIM_MOSTRA) begin
                    timer_d  = '0;
                    estado_d = ST_MOSTRA_APAGADO;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_MOSTRA_APAGADO: begin
                if (timer_q == FIM_MOSTRA) begin
                    timer_d = '0;
                    if (end_q == rodada_q) begin
                        end_d    = '0;
                        estado_d = ST_ESPERA_JOGADA;
                    end else begin
                        end_d    = end_q + AW'(1);
                        estado_d = ST_MOSTRA_ACESO;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_ESPERA_JOGADA: begin
                timer_d = timer_q + TW'(1);
                if (pressionou) begin
                    jogada_d = chaves;
                    estado_d = ST_COMPARA;
                end else if (timer_q == FIM_TIMEOUT) begin
                    timeout_d = 1'b1;
                    estado_d  = ST_FINAL_PERDEU;
                end
            end
            ST_COMPARA: begin
                if (!jogada_unica || jogada_q != alvo) begin
                    timeout_d = 1'b0;
                    estado_d  = ST_FINAL_PERDEU;
                end else if (end_q < rodada_q) begin
                    end_d    = end_q + AW'(1);
                    timer_d  = '0;
                    estado_d = ST_ESPERA_JOGADA;
                end else if (rodada_q == ULTIMO) begin
                    estado_d = ST_FINAL_GANHOU;
                end else begin
                    estado_d = ST_PROXIMA_RODADA;
                end
            end
            ST_PROXIMA_RODADA: begin
                rodada_d = rodada_q + AW'(1);
                estado_d = ST_PREPARA_RODADA;
            end
            default: estado_d = ST_INICIAL;
        endcase

        // Start and restart share one path; iniciar is ignored elsewhere.
        if (iniciar && (estado_q == ST_INICIAL || estado_q == ST_FINAL_GANHOU ||
                        estado_q == ST_FINAL_PERDEU)) begin
            modo_d        = modo;
            lfsr_carregar = 1'b1;
            end_d         = '0;
            rodada_d      = '0;
            timer_d       = '0;
            timeout_d     = 1'b0;
            jogada_d      = '0;
            estado_d      = ST_PREENCHE;
        end

        // Outputs are decoded from the next state so they are registered
        // yet aligned with db_estado.
        leds_d   = (estado_d == ST_MOSTRA_ACESO) ? (N_BOTOES'(1) << mem_q[end_d]) : '0;
        pronto_d = (estado_d == ST_FINAL_GANHOU) || (estado_d == ST_FINAL_PERDEU);
        ganhou_d = (estado_d == ST_FINAL_GANHOU);
        perdeu_d = (estado_d == ST_FINAL_PERDEU);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q     <= ST_INICIAL;
            modo_q       <= 1'b0;
            end_q        <= '0;
            rodada_q     <= '0;
            timer_q      <= '0;
            timeout_q    <= 1'b0;
            jogada_q     <= '0;
            chaves_ant_q <= 1'b0;
            leds_q       <= '0;
            pronto_q     <= 1'b0;
            ganhou_q     <= 1'b0;
            perdeu_q     <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            modo_q       <= modo_d;
            end_q        <= end_d;
            rodada_q     <= rodada_d;
            timer_q      <= timer_d;
            timeout_q    <= timeout_d;
            jogada_q     <= jogada_d;
            chaves_ant_q <= chaves_ant_d;
            leds_q       <= leds_d;
            pronto_q     <= pronto_d;
            ganhou_q     <= ganhou_d;
            perdeu_q     <= perdeu_d;
        end
    end

    // NOTE: the sequence memory has no reset; every word is rewritten in
    // preenche before it is read, and a reset port would block RAM mapping.
    always_ff @(posedge clock) begin
        if (mem_we && !reset) begin
            mem_q[end_q] <= mem_wdata;
        end
    end

    assign leds        = leds_q;
    assign pronto      = pronto_q;
    assign ganhou      = ganhou_q;
    assign perdeu      = perdeu_q;
    assign db_timeout  = timeout_q;
    assign db_estado   = estado_q;
    assign db_rodada   = 8'(rodada_q);
    assign db_endereco = 8'(end_q);
    assign db_jogada   = jogada_q;

endmodule
